// File: rtl/chip8_keypad.sv
// CHIP-8 hex keypad front end: per-key synchronizer and debouncer, press pulses,
// and the blocking key-read handshake (Fx0A) used by the CPU.
module chip8_keypad #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] keys_raw,
    output logic [15:0] keys,
    output logic [15:0] key_press,
    input  logic        wait_req,
    output logic        wait_ack,
    output logic [3:0]  wait_key
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HELD,
        DONE
    } wait_state_e;

    logic [15:0] sync1_q;
    logic [15:0] sync2_q;
    logic [15:0] cnt_q [16];
    logic [15:0] cnt_d [16];
    logic [15:0] keys_q;
    logic [15:0] keys_d;
    logic [15:0] press_q;
    logic [15:0] press_d;

    wait_state_e state_q;
    logic        ack_q;
    logic [3:0]  wkey_q;
    logic [3:0]  low_idx;

    // Counter tracks how long the synced level has disagreed with the debounced one.
    always_comb begin
        keys_d = keys_q;
        for (int unsigned i = 0; i < 16; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != keys_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    keys_d[i] = ~keys_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
        press_d = keys_d & ~keys_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            keys_q  <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            keys_q  <= keys_d;
            press_q <= press_d;
            for (int unsigned i = 0; i < 16; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Scan from the top down so the lowest pressed index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (press_q[i-1]) begin
                low_idx = 4'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            wkey_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wait_req) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!wait_req) begin
                        state_q <= IDLE;
                    end else if (|press_q) begin
                        wkey_q  <= low_idx;
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!wait_req) begin
                        state_q <= IDLE;
                    end else if (!keys_q[wkey_q]) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign keys      = keys_q;
    assign key_press = press_q;
    assign wait_ack  = ack_q;
    assign wait_key  = wkey_q;

endmodule

// File: tb/tb_chip8_keypad.sv
// Bench for chip8_keypad: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a window-based behavioural model.
module tb_chip8_keypad;

    localparam int unsigned DB = 16;

    logic        clk;
    logic        reset;
    logic [15:0] keys_raw;
    logic [15:0] keys;
    logic [15:0] key_press;
    logic        wait_req;
    logic        wait_ack;
    logic [3:0]  wait_key;

    chip8_keypad #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_raw  (keys_raw),
        .keys      (keys),
        .key_press (key_press),
        .wait_req  (wait_req),
        .wait_ack  (wait_ack),
        .wait_key  (wait_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int ack_cnt = 0;
    int press5_cnt = 0;
    int press2_cnt = 0;

    // ---------------- behavioural model ----------------
    logic [15:0] m_s1 = '0;
    logic [15:0] m_s2 = '0;
    logic [15:0] m_keys = '0;
    logic [15:0] m_press = '0;
    logic [15:0] hist[$];
    int          m_phase = 0;   // 0 idle, 1 armed, 2 held, 3 done
    logic        m_ack = 1'b0;
    logic [3:0]  m_key = '0;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_keys = '0; m_press = '0;
        hist.delete();
        m_phase = 0; m_ack = 1'b0; m_key = '0;
    endtask

    task automatic model_step();
        logic [15:0] seen;
        logic [15:0] nk;
        bit          all_diff;
        case (m_phase)
            0: if (wait_req) m_phase = 1;
            1: begin
                if (!wait_req) m_phase = 0;
                else if (m_press != 0) begin
                    m_key = lowest(m_press);
                    m_phase = 2;
                end
            end
            2: begin
                if (!wait_req) m_phase = 0;
                else if (!m_keys[m_key]) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
        m_ack = (m_phase == 3);
        // A key flips once the last DB synced samples all disagree with it.
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = keys_raw;
        hist.push_back(seen);
        if (hist.size() > DB) void'(hist.pop_front());
        nk = m_keys;
        if (hist.size() == DB) begin
            for (int i = 0; i < 16; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < hist.size(); j++) begin
                    if (hist[j][i] == m_keys[i]) all_diff = 1'b0;
                end
                if (all_diff) nk[i] = ~m_keys[i];
            end
        end
        m_press = nk & ~m_keys;
        m_keys = nk;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else model_step();
    end

    // ---------------- per-cycle compare and monitors ----------------
    always @(negedge clk) begin
        if (wait_ack) ack_cnt++;
        if (key_press[5]) press5_cnt++;
        if (key_press[2]) press2_cnt++;
        if (chk_on) begin
            total++;
            if (keys !== m_keys || key_press !== m_press || wait_ack !== m_ack || wait_key !== m_key) begin
                bad++;
                $display("FAIL model t=%0t: keys=%h/%h press=%h/%h ack=%b/%b wkey=%h/%h (got/want)",
                         $time, keys, m_keys, key_press, m_press, wait_ack, m_ack, wait_key, m_key);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int   base;
    bit   got;
    int   cyc, fall_cyc, ack_cyc;
    logic prev_k10;

    initial begin
        reset = 1'b1; keys_raw = '0; wait_req = 1'b0;
        tick(1);
        chk_on = 1'b1;
        tick(2);
        @(negedge clk);
        chk("reset_outs", {keys, key_press}, 32'h0);
        chk("reset_wait", {27'd0, wait_ack, wait_key}, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // clean press of key 1
        keys_raw = 16'h0002;
        tick(17);
        @(negedge clk);
        chk("press_k16_keys", 32'(keys), 32'h0);
        tick(1);
        @(negedge clk);
        chk("press_k17_keys", 32'(keys), 32'h2);
        chk("press_k17_pulse", 32'(key_press), 32'h2);
        tick(1);
        @(negedge clk);
        chk("press_k18_pulse", 32'(key_press), 32'h0);
        tick(1);
        keys_raw = '0;
        tick(20);

        // bounce on key 5
        press5_cnt = 0;
        keys_raw[5] = 1'b1; tick(10);
        keys_raw[5] = 1'b0; tick(3);
        keys_raw[5] = 1'b1;
        tick(17);
        @(negedge clk);
        chk("bounce_k16", 32'(keys[5]), 32'h0);
        tick(1);
        @(negedge clk);
        chk("bounce_k17", 32'(keys[5]), 32'h1);
        tick(5);
        chk("bounce_pulses", press5_cnt, 32'd1);
        keys_raw = '0;
        tick(20);

        // blocking read with key 3 already down
        keys_raw = 16'h0008; tick(20);
        base = ack_cnt;
        wait_req = 1'b1; tick(5);
        keys_raw = '0; tick(20);
        keys_raw = 16'h0400; tick(20);
        chk("read_no_early_ack", ack_cnt - base, 32'd0);
        keys_raw = '0;
        got = 1'b0; prev_k10 = 1'b1; fall_cyc = -100; ack_cyc = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (prev_k10 && !keys[10]) fall_cyc = cyc;
            prev_k10 = keys[10];
            if (wait_ack) begin got = 1'b1; ack_cyc = cyc; break; end
        end
        chk("read_ack_seen", 32'(got), 32'h1);
        chk("read_wait_key", 32'(wait_key), 32'hA);
        chk("read_ack_lat", ack_cyc - fall_cyc, 32'd1);
        tick(1);
        wait_req = 1'b0; tick(3);
        chk("read_one_ack", ack_cnt - base, 32'd1);

        // simultaneous press of 7 and C
        base = ack_cnt;
        wait_req = 1'b1; tick(3);
        keys_raw = 16'h1080; tick(20);
        keys_raw = 16'h0080; tick(20);
        chk("simul_hold_on7", ack_cnt - base, 32'd0);
        keys_raw = '0;
        got = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (wait_ack) begin got = 1'b1; break; end
        end
        chk("simul_ack_seen", 32'(got), 32'h1);
        chk("simul_wait_key", 32'(wait_key), 32'h7);
        tick(1);
        wait_req = 1'b0; tick(3);

        // abort while HELD on key 4
        base = ack_cnt;
        wait_req = 1'b1; tick(3);
        keys_raw = 16'h0010; tick(20);
        wait_req = 1'b0; tick(1);
        keys_raw = '0; tick(25);
        chk("abort_no_ack", ack_cnt - base, 32'd0);
        chk("abort_key_kept", 32'(wait_key), 32'h4);

        // reset while HELD on key 2
        base = ack_cnt;
        wait_req = 1'b1; tick(3);
        keys_raw = 16'h0004; tick(20);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {keys, key_press}, 32'h0);
        chk("rst_mid_wait", {27'd0, wait_ack, wait_key}, 32'h0);
        tick(2);
        press2_cnt = 0;
        reset = 1'b0;
        tick(DB + 1);
        @(negedge clk);
        chk("rst_rel_early", 32'(keys[2]), 32'h0);
        tick(1);
        @(negedge clk);
        chk("rst_rel_keys", 32'(keys[2]), 32'h1);
        chk("rst_rel_pulse", 32'(key_press), 32'h4);
        tick(3);
        chk("rst_rearm_key", 32'(wait_key), 32'h2);
        wait_req = 1'b0; tick(1);
        keys_raw = '0; tick(25);
        chk("rst_one_pulse", press2_cnt, 32'd1);
        chk("rst_no_ack", ack_cnt - base, 32'd0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) keys_raw[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) wait_req = ~wait_req;
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1; tick(1); reset = 1'b0;
            end
            tick(1);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
